// File: rtl/sccb_write_arbiter.sv
// Round-robin arbiter sharing the SCCB register-write engine between the host
// path (port 0) and the AE/AF tuning path (port 1), with retry, timeout and bus-idle gap.
//
// state     | meaning
// S_IDLE    | waiting for init_done, engine idle and a request
// S_LAUNCH  | one-cycle eng_start with latched addr/data
// S_WAIT    | waiting for eng_done or timeout
// S_GAP     | enforced bus-idle gap before next launch
module sccb_write_arbiter #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int GAP_CYCLES     = 2048,
  parameter int MAX_RETRY      = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_done,
  input  logic        r0_req,
  input  logic [15:0] r0_addr,
  input  logic [7:0]  r0_data,
  output logic        r0_ack,
  output logic        r0_err,
  input  logic        r1_req,
  input  logic [15:0] r1_addr,
  input  logic [7:0]  r1_data,
  output logic        r1_ack,
  output logic        r1_err,
  output logic        eng_start,
  output logic [15:0] eng_addr,
  output logic [7:0]  eng_data,
  input  logic        eng_busy,
  input  logic        eng_done,
  input  logic        eng_nack,
  output logic        arb_busy,
  output logic        owner,
  output logic [7:0]  err_count
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  // Loaded in LAUNCH; the terminal count lands TIMEOUT_CYCLES-1 cycles after launch
  localparam logic [TO_W-1:0]  TO_LOAD   = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_GAP} state_t;

  state_t            state, state_nxt;
  logic              last_owner;
  logic [2:0]        retry_cnt;
  logic              retry_pend;
  logic [TO_W-1:0]   to_cnt;
  logic [GAP_W-1:0]  gap_cnt;

  logic grant, grant_port, done_ok, done_retry, fail;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    done_ok    = 1'b0;
    done_retry = 1'b0;
    fail       = 1'b0;
    case (state)
      S_IDLE: begin
        if (init_done && !eng_busy && (r0_req || r1_req)) begin
          grant      = 1'b1;
          // On a tie the port that did not win last time is served
          grant_port = r1_req && (!r0_req || !last_owner);
          state_nxt  = S_LAUNCH;
        end
      end
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT: begin
        if (eng_done) begin
          if (!eng_nack)                  done_ok    = 1'b1;
          else if (retry_cnt < RETRY_LIM) done_retry = 1'b1;
          else                            fail       = 1'b1;
          state_nxt = S_GAP;
        end else if (to_cnt == '0) begin
          fail      = 1'b1;
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = retry_pend ? S_LAUNCH : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      eng_addr   <= '0;
      eng_data   <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      r0_ack     <= 1'b0;
      r0_err     <= 1'b0;
      r1_ack     <= 1'b0;
      r1_err     <= 1'b0;
      err_count  <= '0;
    end else begin
      if (grant) begin
        eng_addr   <= grant_port ? r1_addr : r0_addr;
        eng_data   <= grant_port ? r1_data : r0_data;
        owner      <= grant_port;
        last_owner <= grant_port;
        retry_cnt  <= '0;
      end

      if (state == S_LAUNCH) begin
        to_cnt     <= TO_LOAD;
        retry_pend <= 1'b0;
      end else if (state == S_WAIT && to_cnt != '0) begin
        to_cnt <= to_cnt - TO_W'(1);
      end

      if (done_retry) begin
        retry_cnt  <= retry_cnt + 3'd1;
        retry_pend <= 1'b1;
      end

      if (state_nxt == S_GAP && state != S_GAP)   gap_cnt <= GAP_LOAD;
      else if (state == S_GAP && gap_cnt != '0)   gap_cnt <= gap_cnt - GAP_W'(1);

      r0_ack <= done_ok && !owner;
      r1_ack <= done_ok &&  owner;
      r0_err <= fail    && !owner;
      r1_err <= fail    &&  owner;

      if (fail && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  assign eng_start = (state == S_LAUNCH);
  assign arb_busy  = (state != S_IDLE);

endmodule

// File: tb/tb_sccb_write_arbiter.sv
// Scoreboard bench for sccb_write_arbiter: expected launches and results are queued
// when requests are raised and compared as the arbiter produces them.
module tb_sccb_write_arbiter;
  localparam int TO = 400;
  localparam int G  = 2048;
  localparam int MR = 2;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        init_done;
  logic        r0_req, r1_req;
  logic [15:0] r0_addr, r1_addr;
  logic [7:0]  r0_data, r1_data;
  logic        r0_ack, r0_err, r1_ack, r1_err;
  logic        eng_start;
  logic [15:0] eng_addr;
  logic [7:0]  eng_data;
  logic        eng_busy, eng_done, eng_nack;
  logic        arb_busy, owner;
  logic [7:0]  err_count;

  sccb_write_arbiter #(.TIMEOUT_CYCLES(TO), .GAP_CYCLES(G), .MAX_RETRY(MR)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .init_done(init_done),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_data(r0_data), .r0_ack(r0_ack), .r0_err(r0_err),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_data(r1_data), .r1_ack(r1_ack), .r1_err(r1_err),
    .eng_start(eng_start), .eng_addr(eng_addr), .eng_data(eng_data),
    .eng_busy(eng_busy), .eng_done(eng_done), .eng_nack(eng_nack),
    .arb_busy(arb_busy), .owner(owner), .err_count(err_count)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        port;
    logic [15:0] addr;
    logic [7:0]  data;
  } launch_t;

  launch_t    launch_q[$];
  logic [3:0] result_q[$];
  int total = 0;
  int bad = 0;
  int exp_err = 0;

  function automatic logic [3:0] res_vec();
    return {r1_err, r1_ack, r0_err, r0_ack};
  endfunction

  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic wait_start(input int limit, output bit seen, output int t);
    seen = 1'b0;
    t = 0;
    for (int i = 0; i < limit; i++) begin
      if (eng_start === 1'b1) begin
        seen = 1'b1;
        t = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic pop_launch(output launch_t e, output bit ok);
    ok = (launch_q.size() != 0);
    e = '0;
    if (ok) e = launch_q.pop_front();
  endtask

  task automatic pop_result(output logic [3:0] r, output bit ok);
    ok = (result_q.size() != 0);
    r = '0;
    if (ok) r = result_q.pop_front();
  endtask

  task automatic respond(input bit nack, input int busy_cycles);
    eng_busy = 1'b1;
    repeat (busy_cycles) tick();
    eng_busy = 1'b0;
    eng_done = 1'b1;
    eng_nack = nack;
    tick();
    eng_done = 1'b0;
    eng_nack = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int starts, output bit idle);
    starts = 0;
    idle = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!arb_busy) begin
        idle = 1'b1;
        break;
      end
      if (eng_start) starts++;
      tick();
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; init_done = 1'b1; r0_req = 1'b1; r1_req = 1'b1;
    r0_addr = 16'h1234; r0_data = 8'h56; r1_addr = 16'h789A; r1_data = 8'hBC;
    eng_busy = 1'b0; eng_done = 1'b0; eng_nack = 1'b0;
    repeat (3) tick();
    total++;
    if ({eng_start, eng_addr, eng_data, res_vec(), arb_busy, owner, err_count} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got start=%b addr=%h data=%h res=%b busy=%b owner=%b errc=%0d, want all 0",
               eng_start, eng_addr, eng_data, res_vec(), arb_busy, owner, err_count);
    end
    r0_req = 1'b0; r1_req = 1'b0; init_done = 1'b0;
    tick();
    sys_rst = 1'b0;
    exp_err = 0;
    tick();
  endtask

  task automatic test_init_gate();
    bit seen, ok;
    int t, busy_n;
    launch_t e;
    logic [3:0] r;
    r0_addr = 16'h3008; r0_data = 8'h42; r0_req = 1'b1;
    launch_q.push_back({1'b0, 16'h3008, 8'h42});
    result_q.push_back(4'b0001);
    wait_start(20, seen, t);
    total++;
    if (seen) begin bad++; $display("FAIL init_gate: eng_start=1 with init_done=0, want 0"); end
    init_done = 1'b1;
    tick();
    total++;
    if (eng_start !== 1'b1) begin bad++; $display("FAIL init_start_latency: eng_start=%b, want 1", eng_start); end
    pop_launch(e, ok);
    total++;
    if (!ok || {owner, eng_addr, eng_data} !== e) begin
      bad++;
      $display("FAIL init_launch: got %b/%h/%h, want %b/%h/%h", owner, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    r0_req = 1'b0;
    respond(1'b0, 4);
    pop_result(r, ok);
    total++;
    if (!ok || res_vec() !== r) begin bad++; $display("FAIL init_ack: got %b, want %b", res_vec(), r); end
    tick();
    total++;
    if (res_vec() !== 4'b0000) begin bad++; $display("FAIL ack_width: got %b, want 0000", res_vec()); end
    busy_n = 1;
    while (arb_busy && busy_n < G + 10) begin
      busy_n++;
      tick();
    end
    total++;
    if (busy_n !== G) begin bad++; $display("FAIL gap_length: arb_busy held %0d cycles after ack, want %0d", busy_n, G); end
  endtask

  task automatic test_round_robin();
    bit seen, ok, idle;
    int t, prev_t, starts;
    launch_t e;
    logic [3:0] r;
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    exp_err = 0;
    tick();
    r0_addr = 16'h1000; r0_data = 8'h11; r1_addr = 16'h2000; r1_data = 8'h22;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        launch_q.push_back({1'b0, 16'h1000, 8'h11});
        result_q.push_back(4'b0001);
      end else begin
        launch_q.push_back({1'b1, 16'h2000, 8'h22});
        result_q.push_back(4'b0100);
      end
    end
    r0_req = 1'b1; r1_req = 1'b1;
    prev_t = 0;
    for (int k = 0; k < 4; k++) begin
      wait_start(G + 20, seen, t);
      total++;
      if (!seen) begin bad++; $display("FAIL rr_start%0d: no eng_start, want one", k); end
      if (k > 0) begin
        total++;
        if (t - prev_t < G + 1) begin bad++; $display("FAIL rr_spacing%0d: %0d cycles, want >= %0d", k, t - prev_t, G + 1); end
      end
      prev_t = t;
      pop_launch(e, ok);
      total++;
      if (!ok || {owner, eng_addr, eng_data} !== e) begin
        bad++;
        $display("FAIL rr_grant%0d: got %b/%h/%h, want %b/%h/%h", k, owner, eng_addr, eng_data, e.port, e.addr, e.data);
      end
      respond(1'b0, 3);
      pop_result(r, ok);
      total++;
      if (!ok || res_vec() !== r) begin bad++; $display("FAIL rr_result%0d: got %b, want %b", k, res_vec(), r); end
      if (k == 3) begin r0_req = 1'b0; r1_req = 1'b0; end
    end
    wait_idle(G + 20, starts, idle);
    total++;
    if (!idle || starts != 0) begin bad++; $display("FAIL rr_idle: idle=%b starts=%0d, want 1/0", idle, starts); end
  endtask

  task automatic test_nack_retry();
    bit seen, ok, idle;
    int t, prev_t, starts;
    launch_t e;
    logic [3:0] r;
    r1_addr = 16'h3503; r1_data = 8'h07; r1_req = 1'b1;
    for (int k = 0; k <= MR; k++) launch_q.push_back({1'b1, 16'h3503, 8'h07});
    result_q.push_back(4'b1000);
    prev_t = 0;
    for (int k = 0; k <= MR; k++) begin
      wait_start(G + 20, seen, t);
      total++;
      if (!seen) begin bad++; $display("FAIL nack_start%0d: no eng_start, want one", k); end
      if (k > 0) begin
        total++;
        if (t - prev_t < G + 1) begin bad++; $display("FAIL nack_spacing%0d: %0d cycles, want >= %0d", k, t - prev_t, G + 1); end
      end
      prev_t = t;
      pop_launch(e, ok);
      total++;
      if (!ok || {owner, eng_addr, eng_data} !== e) begin
        bad++;
        $display("FAIL nack_launch%0d: got %b/%h/%h, want %b/%h/%h", k, owner, eng_addr, eng_data, e.port, e.addr, e.data);
      end
      if (k == 0) r1_req = 1'b0;
      respond(1'b1, 2);
      if (k < MR) begin
        total++;
        if (res_vec() !== 4'b0000) begin bad++; $display("FAIL nack_early_pulse%0d: got %b, want 0000", k, res_vec()); end
      end else begin
        pop_result(r, ok);
        total++;
        if (!ok || res_vec() !== r) begin bad++; $display("FAIL nack_err: got %b, want %b", res_vec(), r); end
        exp_err++;
        total++;
        if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL nack_errcount: got %0d, want %0d", err_count, exp_err); end
      end
    end
    tick();
    total++;
    if (res_vec() !== 4'b0000) begin bad++; $display("FAIL nack_err_width: got %b, want 0000", res_vec()); end
    wait_idle(G + 20, starts, idle);
    total++;
    if (!idle || starts != 0) begin bad++; $display("FAIL nack_no_relaunch: idle=%b starts=%0d, want 1/0", idle, starts); end
  endtask

  task automatic test_timeout();
    bit seen, ok;
    int t0, t1, t2;
    launch_t e;
    logic [3:0] r;
    r0_addr = 16'h3100; r0_data = 8'h55; r0_req = 1'b1;
    launch_q.push_back({1'b0, 16'h3100, 8'h55});
    result_q.push_back(4'b0010);
    wait_start(G + 20, seen, t0);
    total++;
    if (!seen) begin bad++; $display("FAIL to_start: no eng_start, want one"); end
    pop_launch(e, ok);
    total++;
    if (!ok || {owner, eng_addr, eng_data} !== e) begin
      bad++;
      $display("FAIL to_launch: got %b/%h/%h, want %b/%h/%h", owner, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    r0_req = 1'b0;
    eng_busy = 1'b1;
    t1 = -1;
    for (int i = 0; i < TO + 20; i++) begin
      tick();
      if (res_vec() != 4'b0000) begin t1 = cyc; break; end
    end
    total++;
    if (t1 - t0 !== TO) begin bad++; $display("FAIL to_latency: err %0d cycles after start, want %0d", t1 - t0, TO); end
    pop_result(r, ok);
    total++;
    if (!ok || res_vec() !== r) begin bad++; $display("FAIL to_err: got %b, want %b", res_vec(), r); end
    exp_err++;
    total++;
    if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL to_errcount: got %0d, want %0d", err_count, exp_err); end
    eng_busy = 1'b0;
    r1_addr = 16'h3200; r1_data = 8'h66; r1_req = 1'b1;
    launch_q.push_back({1'b1, 16'h3200, 8'h66});
    result_q.push_back(4'b0100);
    wait_start(G + 20, seen, t2);
    total++;
    if (!seen || t2 - t1 < G) begin bad++; $display("FAIL to_next_grant: seen=%b gap=%0d, want 1/>=%0d", seen, t2 - t1, G); end
    pop_launch(e, ok);
    total++;
    if (!ok || {owner, eng_addr, eng_data} !== e) begin
      bad++;
      $display("FAIL to_next_launch: got %b/%h/%h, want %b/%h/%h", owner, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    r1_req = 1'b0;
    respond(1'b0, 3);
    pop_result(r, ok);
    total++;
    if (!ok || res_vec() !== r) begin bad++; $display("FAIL to_next_ack: got %b, want %b", res_vec(), r); end
  endtask

  task automatic test_done_at_timeout();
    bit seen, ok;
    int t0;
    launch_t e;
    logic [3:0] r, pulses;
    r0_addr = 16'h3300; r0_data = 8'h77; r0_req = 1'b1;
    launch_q.push_back({1'b0, 16'h3300, 8'h77});
    result_q.push_back(4'b0001);
    wait_start(G + 20, seen, t0);
    total++;
    if (!seen) begin bad++; $display("FAIL tc_start: no eng_start, want one"); end
    pop_launch(e, ok);
    total++;
    if (!ok || {owner, eng_addr, eng_data} !== e) begin
      bad++;
      $display("FAIL tc_launch: got %b/%h/%h, want %b/%h/%h", owner, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    r0_req = 1'b0;
    eng_busy = 1'b1;
    pulses = 4'b0000;
    repeat (TO - 1) begin
      tick();
      pulses |= res_vec();
    end
    eng_busy = 1'b0;
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    pop_result(r, ok);
    total++;
    if (!ok || (res_vec() | pulses) !== r) begin
      bad++;
      $display("FAIL tc_done_wins: got %b (earlier %b), want %b", res_vec(), pulses, r);
    end
    total++;
    if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL tc_errcount: got %0d, want %0d", err_count, exp_err); end
  endtask

  task automatic test_reset_mid();
    bit seen, ok, idle;
    int t, starts;
    launch_t e;
    logic [3:0] r, pulses;
    r0_addr = 16'h3400; r0_data = 8'h88; r0_req = 1'b1;
    launch_q.push_back({1'b0, 16'h3400, 8'h88});
    wait_start(G + 20, seen, t);
    total++;
    if (!seen) begin bad++; $display("FAIL rm_start: no eng_start, want one"); end
    pop_launch(e, ok);
    total++;
    if (!ok || {owner, eng_addr, eng_data} !== e) begin
      bad++;
      $display("FAIL rm_launch: got %b/%h/%h, want %b/%h/%h", owner, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    r0_req = 1'b0;
    eng_busy = 1'b1;
    repeat (5) tick();
    r1_addr = 16'h3500; r1_data = 8'h99; r1_req = 1'b1;
    launch_q.push_back({1'b1, 16'h3500, 8'h99});
    sys_rst = 1'b1;
    #1;
    total++;
    if ({eng_start, eng_addr, eng_data, res_vec(), arb_busy, owner, err_count} !== '0) begin
      bad++;
      $display("FAIL rm_outputs: got start=%b addr=%h data=%h res=%b busy=%b owner=%b errc=%0d, want all 0",
               eng_start, eng_addr, eng_data, res_vec(), arb_busy, owner, err_count);
    end
    pulses = 4'b0000;
    repeat (3) begin
      tick();
      pulses |= res_vec();
    end
    eng_busy = 1'b0;
    sys_rst = 1'b0;
    exp_err = 0;
    result_q.push_back(4'b0100);
    wait_start(20, seen, t);
    total++;
    if (!seen || pulses !== 4'b0000) begin bad++; $display("FAIL rm_regrant: seen=%b pulses=%b, want 1/0000", seen, pulses); end
    pop_launch(e, ok);
    total++;
    if (!ok || {owner, eng_addr, eng_data} !== e) begin
      bad++;
      $display("FAIL rm_r1_launch: got %b/%h/%h, want %b/%h/%h", owner, eng_addr, eng_data, e.port, e.addr, e.data);
    end
    total++;
    if (err_count !== 8'(exp_err)) begin bad++; $display("FAIL rm_errcount: got %0d, want %0d", err_count, exp_err); end
    r1_req = 1'b0;
    respond(1'b0, 3);
    pop_result(r, ok);
    total++;
    if (!ok || res_vec() !== r) begin bad++; $display("FAIL rm_ack: got %b, want %b", res_vec(), r); end
    wait_idle(G + 20, starts, idle);
    total++;
    if (!idle || starts != 0 || launch_q.size() != 0 || result_q.size() != 0) begin
      bad++;
      $display("FAIL rm_drain: idle=%b starts=%0d launches_left=%0d results_left=%0d, want 1/0/0/0",
               idle, starts, launch_q.size(), result_q.size());
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_init_gate();
    test_round_robin();
    test_nack_retry();
    test_timeout();
    test_done_at_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
